// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the two-player status link.
// Status byte layout: {start_pressed, game_ended, score[5:0]}.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } link_tx_state_t;

    localparam int LINK_START_BIT = 7;
    localparam int LINK_END_BIT   = 6;
    localparam int LINK_SCORE_MSB = 5;

    localparam int unsigned LINK_HEARTBEAT_CYCLES = 650_000;
    localparam int unsigned LINK_TIMEOUT_CYCLES   = 6_500_000;
    localparam int unsigned LINK_CONFIRM_COUNT    = 2;
    localparam int unsigned LINK_ACK_TIMEOUT      = 16;

    // 3-bit increment that sticks at 7 instead of wrapping.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/link_rx_filter.sv
// link_rx_filter: accepts an enemy status byte only after it has been
// received identically CONFIRM_COUNT times in a row, and tracks liveness.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_rx_valid         one-cycle pulse, new byte on i_rx_data
//   i_rx_data[7:0]     received byte
//   o_enemy_status     last accepted byte (cleared on link timeout)
//   o_enemy_changed    one-cycle pulse when o_enemy_status updates
//   o_link_up          set by any accepted byte, cleared on timeout
module link_rx_filter
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LINK_TIMEOUT_CYCLES,
    parameter int unsigned CONFIRM_COUNT  = LINK_CONFIRM_COUNT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_enemy_status,
    output logic       o_enemy_changed,
    output logic       o_link_up
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      CONF_REQ = 3'(CONFIRM_COUNT);

    logic [7:0]      r_cand;
    logic [2:0]      r_conf;
    logic [7:0]      r_enemy;
    logic            r_changed;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_link_up;

    logic [2:0] w_conf_nxt;
    logic       w_accept;

    assign w_conf_nxt = (i_rx_data == r_cand) ? sat_inc3(r_conf) : 3'd1;
    assign w_accept   = (w_conf_nxt >= CONF_REQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand    <= 8'h00;
            r_conf    <= 3'd0;
            r_enemy   <= 8'h00;
            r_changed <= 1'b0;
            r_to_cnt  <= '0;
            r_link_up <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (i_rx_valid) begin
                r_to_cnt <= '0;
                r_cand   <= i_rx_data;
                r_conf   <= w_conf_nxt;
                if (w_accept) begin
                    // A confirmed repeat of the current value still proves liveness.
                    r_link_up <= 1'b1;
                    if (i_rx_data != r_enemy) begin
                        r_enemy   <= i_rx_data;
                        r_changed <= 1'b1;
                    end
                end
            end else if (r_to_cnt == TO_LAST) begin
                // Counter parks here; enemy flags read 0 while the link is down.
                r_link_up <= 1'b0;
                r_enemy   <= 8'h00;
                r_conf    <= 3'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign o_enemy_status  = r_enemy;
    assign o_enemy_changed = r_changed;
    assign o_link_up       = r_link_up;

endmodule

// File: rtl/game_link_ctl.sv
// game_link_ctl: sequences the two-player UART status exchange.
// Sends the local status byte on change and as a periodic heartbeat through
// a start/busy handshake, and filters/monitors the received enemy byte.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_local_status[7:0] {start_pressed, game_ended, score[5:0]}
//   i_tx_busy           UART transmitter busy
//   o_tx_start          one-cycle send request
//   o_tx_data[7:0]      byte to send, held from o_tx_start until busy falls
//   i_rx_valid          one-cycle pulse, new byte on i_rx_data
//   i_rx_data[7:0]      received byte
//   o_enemy_status      last accepted enemy byte
//   o_enemy_changed     one-cycle pulse when o_enemy_status updates
//   o_link_up           enemy link alive
module game_link_ctl
    import game_pkg::*;
#(
    parameter int unsigned HEARTBEAT_CYCLES = LINK_HEARTBEAT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = LINK_TIMEOUT_CYCLES,
    parameter int unsigned CONFIRM_COUNT    = LINK_CONFIRM_COUNT,
    parameter int unsigned ACK_TIMEOUT      = LINK_ACK_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_local_status,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_enemy_status,
    output logic       o_enemy_changed,
    output logic       o_link_up
);

    localparam int HB_W  = $clog2(HEARTBEAT_CYCLES);
    localparam int ACK_W = $clog2(ACK_TIMEOUT);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    link_tx_state_t   r_state;
    link_tx_state_t   w_state_nxt;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_last_sent;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [HB_W-1:0]  r_hb_cnt;

    logic w_send_req;
    logic w_launch;
    logic w_done;

    // Compared live against last_sent, so a change made mid-transfer is
    // picked up as soon as the FSM returns to IDLE.
    assign w_send_req = (i_local_status != r_last_sent) || (r_hb_cnt == HB_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_send_req && !i_tx_busy) begin
                    w_state_nxt = WAIT_ACK;
                    w_launch    = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (i_tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_ack_cnt == ACK_LAST) begin
                    // No ack: back to IDLE with last_sent untouched, so it retries.
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_tx_data doubles as the snapshot of the byte in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_last_sent <= 8'h00;
            r_ack_cnt   <= '0;
            r_hb_cnt    <= '0;
        end else begin
            r_tx_start <= w_launch;
            if (w_launch) begin
                r_tx_data <= i_local_status;
            end
            if (w_done) begin
                r_last_sent <= r_tx_data;
            end
            if (w_launch) begin
                r_ack_cnt <= '0;
            end else if (r_state == WAIT_ACK && r_ack_cnt != ACK_LAST) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
            if (w_done) begin
                r_hb_cnt <= '0;
            end else if (r_state == IDLE && r_hb_cnt != HB_LAST) begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

    link_rx_filter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CONFIRM_COUNT  (CONFIRM_COUNT)
    ) u_rx_filter (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_rx_valid      (i_rx_valid),
        .i_rx_data       (i_rx_data),
        .o_enemy_status  (o_enemy_status),
        .o_enemy_changed (o_enemy_changed),
        .o_link_up       (o_link_up)
    );

endmodule

// File: tb/tb_game_link_ctl.sv
// tb_game_link_ctl: directed bench for game_link_ctl with a simple UART TX
// model (busy rises 2 cycles after tx_start, held 20 cycles).
module tb_game_link_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] local_status;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] enemy_status;
    logic       enemy_changed;
    logic       link_up;

    int n_cmp = 0;
    int n_bad = 0;

    int   n_chg = 0;
    int   n_start = 0;
    int   n_unstable = 0;
    logic hold = 1'b0;
    logic [7:0] hold_val = 8'h00;
    logic busy_q = 1'b0;
    logic m_en = 1'b0;
    int   m_t = -1;
    int   c;

    always #5 clk = ~clk;

    game_link_ctl #(
        .HEARTBEAT_CYCLES (100),
        .TIMEOUT_CYCLES   (500),
        .CONFIRM_COUNT    (2),
        .ACK_TIMEOUT      (16)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_local_status  (local_status),
        .i_tx_busy       (tx_busy),
        .o_tx_start      (tx_start),
        .o_tx_data       (tx_data),
        .i_rx_valid      (rx_valid),
        .i_rx_data       (rx_data),
        .o_enemy_status  (enemy_status),
        .o_enemy_changed (enemy_changed),
        .o_link_up       (link_up)
    );

    // Monitor plus TX model, both on the falling edge.
    always @(negedge clk) begin
        if (enemy_changed) n_chg++;
        if (tx_start) n_start++;
        if (!rst_n) begin
            hold = 1'b0;
        end else if (tx_start) begin
            hold     = 1'b1;
            hold_val = tx_data;
        end else if (hold) begin
            if (tx_data !== hold_val) n_unstable++;
            if (busy_q && !tx_busy) hold = 1'b0;
        end
        busy_q = tx_busy;
        if (!m_en) begin
            tx_busy = 1'b0;
            m_t     = -1;
        end else if (m_t < 0) begin
            if (tx_start) m_t = 0;
        end else begin
            m_t++;
            if (m_t == 2) begin
                tx_busy = 1'b1;
            end else if (m_t == 22) begin
                tx_busy = 1'b0;
                m_t     = -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until tx_start is seen; -1 if the budget runs out.
    task automatic wait_start(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget) begin
            tick(1);
            cnt++;
            if (tx_start) return;
        end
        cnt = -1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        local_status = 8'h00;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        tick(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_enemy", enemy_status, 8'h00);
        chk("rst_changed", enemy_changed, 0);
        chk("rst_link", link_up, 0);
        rst_n = 1'b1;
        m_en  = 1'b1;

        // Status change, then heartbeat resend.
        tick(10);
        chk("no_send_idle", n_start, 0);
        local_status = 8'h85;
        tick(1);
        chk("start_85", tx_start, 1);
        chk("data_85", tx_data, 8'h85);
        tick(1);
        chk("start_one_cycle", tx_start, 0);
        wait_start(200, c);
        chk("hb_interval", c, 122);
        chk("hb_data", tx_data, 8'h85);

        // Change during WAIT_DONE is sent right after the current byte.
        tick(10);
        local_status = 8'h86;
        wait_start(100, c);
        chk("chg_interval", c, 14);
        chk("chg_data", tx_data, 8'h86);

        // No ack: retry every 17 cycles with the same byte.
        tick(30);
        m_en = 1'b0;
        local_status = 8'h12;
        wait_start(10, c);
        chk("retry_first", c, 1);
        chk("retry_data0", tx_data, 8'h12);
        wait_start(40, c);
        chk("retry_int1", c, 17);
        wait_start(40, c);
        chk("retry_int2", c, 17);
        chk("retry_data2", tx_data, 8'h12);
        m_en = 1'b1;
        wait_start(200, c);
        chk("post_retry_hb", c, 123);
        chk("post_retry_data", tx_data, 8'h12);
        chk("tx_data_stable", n_unstable, 0);

        // RX filter: C3 never published, 41 confirmed on the second arrival.
        rx_byte(8'hC3);
        chk("rx_c3_enemy", enemy_status, 8'h00);
        chk("rx_c3_changed", enemy_changed, 0);
        tick(2);
        rx_byte(8'h41);
        chk("rx_41a_enemy", enemy_status, 8'h00);
        chk("rx_41a_link", link_up, 0);
        tick(2);
        rx_byte(8'h41);
        chk("rx_41b_enemy", enemy_status, 8'h41);
        chk("rx_41b_changed", enemy_changed, 1);
        chk("rx_41b_link", link_up, 1);
        tick(1);
        chk("rx_changed_drop", enemy_changed, 0);
        chk("rx_chg_count1", n_chg, 1);

        // rx_valid on the timeout cycle wins.
        tick(498);
        chk("to_edge_link", link_up, 1);
        rx_byte(8'h55);
        chk("to_rx_wins_link", link_up, 1);
        chk("to_rx_wins_enemy", enemy_status, 8'h41);

        // Full timeout.
        tick(499);
        chk("to_pre_link", link_up, 1);
        chk("to_pre_enemy", enemy_status, 8'h41);
        tick(1);
        chk("to_link", link_up, 0);
        chk("to_enemy", enemy_status, 8'h00);
        chk("to_no_pulse", n_chg, 1);

        // Confirmed byte equal to current enemy_status raises link_up silently.
        rx_byte(8'h00);
        tick(2);
        rx_byte(8'h00);
        chk("eq_link", link_up, 1);
        chk("eq_enemy", enemy_status, 8'h00);
        chk("eq_no_pulse", n_chg, 1);
        tick(2);
        rx_byte(8'h41);
        tick(2);
        rx_byte(8'h41);
        chk("re41_enemy", enemy_status, 8'h41);
        tick(2);
        rx_byte(8'h41);
        tick(1);
        chk("re41_chg_count", n_chg, 2);

        // Reset in WAIT_DONE.
        local_status = 8'h33;
        wait_start(10, c);
        chk("pre_rst_start", c, 1);
        tick(10);
        #2;
        rst_n = 1'b0;
        m_en  = 1'b0;
        #1;
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_enemy", enemy_status, 8'h00);
        chk("mid_rst_changed", enemy_changed, 0);
        chk("mid_rst_link", link_up, 0);
        local_status = 8'h00;
        tick(2);
        chk("in_rst_tx_start", tx_start, 0);
        rst_n = 1'b1;
        m_en  = 1'b1;
        wait_start(150, c);
        chk("post_rst_hb", c, 100);
        chk("post_rst_data", tx_data, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_link_ctl.md
# game_link_ctl

Sequences the two-player UART status exchange for the game control top level. It transmits the local status byte (start_pressed, game_ended, score[5:0]) whenever that byte changes, plus a periodic heartbeat, using a start/busy handshake with the UART transmitter. It filters received enemy bytes, publishing a byte only after it has arrived identically CONFIRM_COUNT times in a row, and it monitors link liveness. It sits between the game control logic and the UART TX/RX cores, replacing the direct byte wiring.

## Interface
- HEARTBEAT_CYCLES, 650_000: idle cycles after a completed send before the unchanged status is resent.
- TIMEOUT_CYCLES, 6_500_000: cycles without rx_valid before the link is declared down.
- CONFIRM_COUNT, 2: consecutive identical rx bytes required to accept a byte (range 1..7).
- ACK_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_start.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- local_status  in  8  {start_pressed, game_ended, score[5:0]} from game control.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle send request.
- tx_data  out  8  byte to send; held stable from tx_start until tx_busy falls.
- rx_valid  in  1  one-cycle pulse, new byte on rx_data.
- rx_data  in  8  received byte.
- enemy_status  out  8  last accepted enemy byte.
- enemy_changed  out  1  one-cycle pulse when enemy_status updates.
- link_up  out  1  enemy link alive.

## Operation
- TX FSM states: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE: send_req = (local_status != last_sent) OR (hb_cnt == HEARTBEAT_CYCLES-1).
  - If send_req and !tx_busy: snapshot <= local_status, tx_data <= local_status, tx_start = 1 for one cycle, ack_cnt <= 0, go to WAIT_ACK.
  - If tx_busy is high, stay in IDLE; the request persists.
- WAIT_ACK:
  - tx_busy high: go to WAIT_DONE.
  - ack_cnt reaches ACK_TIMEOUT-1: go to IDLE with last_sent unchanged, so the byte is retried.
- WAIT_DONE:
  - tx_busy low: last_sent <= snapshot, hb_cnt <= 0, go to IDLE.
  - A local_status change during WAIT_ACK or WAIT_DONE is not lost: IDLE re-evaluates the comparison and sends the new value next.
- hb_cnt increments only in IDLE and saturates at HEARTBEAT_CYCLES-1.
- RX filter:
  - On rx_valid: if rx_data == cand, conf_cnt <= sat(conf_cnt+1); else cand <= rx_data, conf_cnt <= 1.
  - When the updated conf_cnt >= CONFIRM_COUNT and cand != enemy_status: enemy_status <= cand, enemy_changed pulses.
  - With CONFIRM_COUNT = 1, every differing byte is accepted immediately.
- Liveness:
  - rx_valid clears to_cnt.
  - link_up sets on the first accepted byte, including a byte equal to the current enemy_status.
  - When to_cnt reaches TIMEOUT_CYCLES-1: link_up <= 0, enemy_status <= 0, conf_cnt <= 0. No enemy_changed pulse. Enemy start/end flags therefore read 0 while the link is down.
- rx_valid in the same cycle as a timeout: rx_valid wins; the counter clears and link_up is unchanged.
- Reset mid-transfer: all state returns to reset values immediately. tx_start never glitches high during or after reset.

## Timing
- Reset values:
  - tx_start = 0, tx_data = 0x00, enemy_status = 0x00, enemy_changed = 0, link_up = 0.
  - FSM = IDLE, last_sent = 0x00, cand = 0x00, all counters 0.
  - After reset, local_status = 0x00 produces no send until the heartbeat expires.
- All outputs are registered.
- tx_start asserts in the cycle after send_req is sampled true in IDLE.
- enemy_changed and the enemy_status update occur in the cycle after the confirming rx_valid.
- link_up falls exactly TIMEOUT_CYCLES cycles after the last rx_valid.
- Minimum spacing between tx_start pulses is 3 cycles (IDLE → WAIT_ACK → WAIT_DONE → IDLE).

## Structure
- Shared package (game_pkg):
  - typedef enum link_tx_state_t {IDLE, WAIT_ACK, WAIT_DONE}.
  - Status field constants: LINK_START_BIT = 7, LINK_END_BIT = 6, LINK_SCORE_MSB = 5.
  - Default HEARTBEAT/TIMEOUT constants.
- Sub-module link_rx_filter holds cand, conf_cnt, enemy_status, enemy_changed, the timeout counter and link_up. The TX FSM stays in game_link_ctl.

## Test plan
Bench parameters: HEARTBEAT_CYCLES = 100, TIMEOUT_CYCLES = 500, CONFIRM_COUNT = 2, ACK_TIMEOUT = 16. The TX model raises tx_busy 2 cycles after tx_start and holds it for 20 cycles.
- local_status 0x00 → 0x85 → one tx_start with tx_data = 0x85 held stable through busy; no further send until 100 idle cycles later, then a heartbeat resend of 0x85.
- local_status changes to 0x86 while in WAIT_DONE → 0x85 completes, then the next tx_start carries 0x86.
- tx_busy never rises → tx_start retried every 17+ cycles with the same byte; last_sent unchanged.
- rx sequence 0xC3, 0x41, 0x41 → enemy_status = 0x41 one cycle after the third rx_valid, enemy_changed pulses once, link_up = 1; 0xC3 is never published.
- No rx for 500 cycles after 0x41 → link_up = 0, enemy_status = 0x00; rx_valid arriving on the timeout cycle keeps link_up = 1.
- rst asserted during WAIT_DONE with enemy_status = 0x41 → all outputs at reset values immediately; no tx_start until the status byte differs from 0x00 or the heartbeat expires.
